seg7_scan_driver: RTL and testbench

Drives the 4-digit multiplexed seven-segment display from the stopwatch/timer's 16-bit packed BCD word. It scans one digit at a time from the system clock, with a dead-time blank between digits to stop ghosting. The BCD input arrives from ripple-clocked counters, so the block captures it only after two consecutive identical samples. It also provides leading-zero blanking, per-digit decimal points and per-digit blinking for alarm/set modes.

---
 rtl/seg7_scan_if.sv | 20 ++
 rtl/seg7_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: BCD/control inputs and scanned display outputs of the
// four-digit seven-segment driver.
interface seg7_scan_if;
   logic [15:0] bcd_num;
   logic        blank_lz;
   logic [3:0]  dp_in;
   logic        blink_en;
   logic [3:0]  blink_mask;
   logic [3:0]  dig;
   logic [6:0]  seg;
   logic        dp;
   modport master (
      output bcd_num, blank_lz, dp_in, blink_en, blink_mask,
      input  dig, seg, dp
   );
   modport slave (
      input  bcd_num, blank_lz, dp_in, blink_en, blink_mask,
      output dig, seg, dp
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit seven-segment scanner with dead-time
// blanking, two-sample input capture, leading-zero blanking and digit blink.
module seg7_scan_driver #(
   parameter int SCAN_DIV       = 12000,
   parameter int DEAD_CYC       = 16,
   parameter int BLINK_TICKS    = 250,
   parameter bit DIG_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic        clk,
   input logic        rstn,
   seg7_scan_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_CYC - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
   localparam logic [3:0]    DIG_OFF   = {4{DIG_ACTIVE_LOW}};
   localparam logic [6:0]    SEG_OFF   = {7{SEG_ACTIVE_LOW}};
   localparam logic          DP_OFF    = SEG_ACTIVE_LOW;

   typedef enum logic {BLANK, ON} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [DW-1:0] dead_q, dead_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic [15:0]   s1_q, disp_q;
   logic [3:0]    dig_q, dig_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          tick, dead_done, lit, vis, lz;
   logic [3:0]    sel, nib, lead;
   logic [6:0]    seg_raw;
   logic          dp_raw;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b0000000;
      endcase
   endfunction

   // The counters feeding bcd_num ripple, so only a value seen on two
   // consecutive cycles is trusted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q   <= '0;
         disp_q <= '0;
      end else begin
         s1_q <= bus.bcd_num;
         if (s1_q == bus.bcd_num) disp_q <= s1_q;
      end
   end

   assign tick      = pre_q == PRE_MAX;
   assign dead_done = dead_q == DEAD_MAX;

   always_comb begin
      pre_d   = tick ? '0 : pre_q + 1'b1;
      state_d = state_q;
      dead_d  = dead_q;
      idx_d   = idx_q;
      if (state_q == BLANK) begin
         state_d = dead_done ? ON : BLANK;
         dead_d  = dead_done ? '0 : dead_q + 1'b1;
      end else if (tick) begin
         state_d = BLANK;
         idx_d   = idx_q + 2'd1;
      end
      bcnt_d  = !bus.blink_en ? '0 : !tick ? bcnt_q : (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + 1'b1;
      phase_d = bus.blink_en && (phase_q ^ (tick && bcnt_q == BLINK_MAX));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= BLANK;
         pre_q   <= '0;
         dead_q  <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         dead_q  <= dead_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end

   // idx 0 is DIG1 (top nibble, bit 3 of the digit/dp/mask vectors).
   assign sel     = 4'b1000 >> idx_q;
   assign nib     = disp_q[{~idx_q, 2'b00} +: 4];
   assign lead[0] = disp_q[15:12] == 4'd0;
   assign lead[1] = lead[0] && disp_q[11:8] == 4'd0;
   assign lead[2] = lead[1] && disp_q[7:4] == 4'd0;
   assign lead[3] = 1'b0;

   always_comb begin
      lit     = state_q == ON;
      vis     = !(phase_q && |(bus.blink_mask & sel));
      lz      = bus.blank_lz && lead[idx_q];
      seg_raw = (lz || !vis) ? 7'd0 : decode(nib);
      dp_raw  = vis && |(bus.dp_in & sel);
      dig_d   = lit ? sel ^ DIG_OFF : DIG_OFF;
      seg_d   = lit ? seg_raw ^ SEG_OFF : SEG_OFF;
      dp_d    = lit ? dp_raw ^ DP_OFF : DP_OFF;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dig_q <= DIG_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
      end else begin
         dig_q <= dig_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign bus.dig = dig_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-level scoreboard checks of the scanned display
// for a table of BCD/control vectors plus capture, blink and reset sequences.
module tb_seg7_scan_driver;
   localparam int SD = 8;
   localparam int DC = 2;
   localparam int BT = 2;
   localparam int FR = 4 * SD;

   typedef struct packed {
      logic [3:0] dig;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   typedef struct packed {
      logic [15:0] bcd;
      logic        lz;
      logic [3:0]  dpi;
      logic [27:0] seg;
      logic [3:0]  dpo;
   } vec_t;

   localparam out_t OFF = '{dig: 4'hF, seg: 7'h7F, dp: 1'b1};

   logic clk = 1'b0;
   logic rstn = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   out_t sb[$];
   vec_t vt[7];

   seg7_scan_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_TICKS(BT),
      .DIG_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = {bus.dig, bus.seg, bus.dp};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got dig=%b seg=%h dp=%b want dig=%b seg=%h dp=%b",
                  name, cyc, act.dig, act.seg, act.dp, exp.dig, exp.seg, exp.dp);
      end
   endtask

   task automatic align(input int ph);
      int n;
      n = 0;
      @(negedge clk);
      while (cyc % FR != ph && n < 4 * FR) begin
         @(negedge clk);
         n++;
      end
      if (cyc % FR != ph) begin
         n_chk++;
         n_fail++;
         $display("FAIL align cyc=%0d want phase %0d", cyc, ph);
      end
   endtask

   task automatic push_vec(input vec_t v, input logic [3:0] dark);
      for (int d = 0; d < 4; d++) begin
         out_t e;
         logic [27:0] sh;
         sh    = v.seg >> (7 * (3 - d));
         e.dig = ~(4'b1000 >> d);
         e.seg = dark[3-d] ? 7'h7F : sh[6:0];
         e.dp  = dark[3-d] ? 1'b1 : v.dpo[3-d];
         sb.push_back(e);
      end
   endtask

   task automatic frame_body(input string name);
      for (int i = 0; i < FR; i++) begin
         int pos;
         @(negedge clk);
         pos = (cyc - 1) % SD;
         if (pos < DC) check(name, OFF);
         else if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s cyc=%0d scoreboard empty", name, cyc);
         end else begin
            check(name, sb[0]);
            if (pos == SD - 1) void'(sb.pop_front());
         end
      end
   endtask

   task automatic apply(input vec_t v);
      bus.bcd_num  = v.bcd;
      bus.blank_lz = v.lz;
      bus.dp_in    = v.dpi;
   endtask

   task automatic run_frame(input string name);
      align(0);
      frame_body(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{16'h1234, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
      vt[1] = '{16'hA0F9, 1'b0, 4'b0100, {7'h7F, 7'h40, 7'h7F, 7'h10}, 4'b1011};
      vt[2] = '{16'h0005, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
      vt[3] = '{16'h0000, 1'b1, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
      vt[4] = '{16'h0105, 1'b1, 4'b0000, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111};
      vt[5] = '{16'h0000, 1'b1, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
      vt[6] = '{16'h8765, 1'b1, 4'b1111, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b0000};
      bus.bcd_num    = '0;
      bus.blank_lz   = 1'b0;
      bus.dp_in      = '0;
      bus.blink_en   = 1'b0;
      bus.blink_mask = '0;
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", OFF);
      apply(vt[0]);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_reset_dead1", OFF);
      @(negedge clk);
      check("post_reset_dead2", OFF);
      @(negedge clk);
      check("first_lit_dig1", '{4'b0111, 7'h79, 1'b1});

      for (int i = 0; i < 7; i++) begin
         apply(vt[i]);
         repeat (4) @(negedge clk);
         push_vec(vt[i], 4'b0000);
         run_frame($sformatf("vec%0d", i));
      end

      // One-cycle glitch 0150 between stable 0059 and 0100, watched in the DIG2 slot.
      bus.bcd_num  = 16'h0059;
      bus.blank_lz = 1'b0;
      bus.dp_in    = '0;
      repeat (4) @(negedge clk);
      align(11);
      bus.bcd_num = 16'h0150;
      @(negedge clk);
      check("glitch_c12", '{4'b1011, 7'h40, 1'b1});
      bus.bcd_num = 16'h0100;
      @(negedge clk);
      check("glitch_c13", '{4'b1011, 7'h40, 1'b1});
      @(negedge clk);
      check("glitch_c14", '{4'b1011, 7'h40, 1'b1});
      @(negedge clk);
      check("glitch_c15", '{4'b1011, 7'h79, 1'b1});
      @(negedge clk);
      check("glitch_c16", '{4'b1011, 7'h79, 1'b1});

      apply(vt[0]);
      bus.blink_mask = 4'b0011;
      repeat (4) @(negedge clk);
      align(0);
      bus.blink_en = 1'b1;
      push_vec(vt[0], 4'b0011);
      frame_body("blink_f1");
      push_vec(vt[0], 4'b0011);
      frame_body("blink_f2");
      align(20);
      check("blink_dark_dig3", '{4'b1101, 7'h7F, 1'b1});
      bus.blink_en = 1'b0;
      @(negedge clk);
      check("blink_drop_lag", '{4'b1101, 7'h7F, 1'b1});
      @(negedge clk);
      check("blink_drop_lit", '{4'b1101, 7'h30, 1'b1});
      bus.blink_mask = '0;
      push_vec(vt[0], 4'b0000);
      run_frame("blink_off");

      align(5);
      #2 rstn = 1'b0;
      #1 check("async_reset", OFF);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("rerst_dead1", OFF);
      @(negedge clk);
      check("rerst_dead2", OFF);
      @(negedge clk);
      check("rerst_dig1", '{4'b0111, 7'h79, 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
